// File: rtl/dbenc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dbenc_pkg : shared constants and types for switch_debounce_encoder |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package dbenc_pkg;
  localparam int NUM_SW              = 3;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 16;

  typedef logic [NUM_SW-1:0] sw_code_t;
endpackage
`default_nettype wire

// File: rtl/switch_debounce_encoder_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | switch_debounce_encoder_if : switch inputs and code outputs        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface switch_debounce_encoder_if;
  dbenc_pkg::sw_code_t sw_raw;
  logic                hold;
  dbenc_pkg::sw_code_t code;
  logic                code_valid;
  logic                code_changed;

  modport master (output sw_raw, output hold,
                  input  code, input code_valid, input code_changed);
  modport slave  (input  sw_raw, input hold,
                  output code, output code_valid, output code_changed);
endinterface
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | debounce_channel : synchroniser, agreement counter and stable flop |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module debounce_channel #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  wire  clk,
  input  wire  rst_n,
  input  wire  i_sw_raw,
  output logic o_stable
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_stable;
  logic                   w_sync;

  assign w_sync   = r_sync[SYNC_STAGES-1];
  assign o_stable = r_stable;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync   <= '0;
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_sw_raw};
      // Any agreeing sample restarts the count, so short glitches never land
      if (w_sync == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        r_stable <= w_sync;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/switch_debounce_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | switch_debounce_encoder : debounced 3-bit code with hold, valid    |
// | and change strobe for the downstream LED decoder. Rev 1.0          |
// +--------------------------------------------------------------------+
module switch_debounce_encoder
  import dbenc_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input wire                        clk,
  input wire                        rst_n,
  switch_debounce_encoder_if.slave  bus
);
  localparam int WARMUP = SYNC_STAGES + DEBOUNCE_CYCLES + 1;
  localparam int WARM_W = $clog2(WARMUP + 1);

  sw_code_t          w_stable;
  sw_code_t          w_next_code;
  sw_code_t          r_code;
  logic              r_valid;
  logic              r_changed;
  logic [WARM_W-1:0] r_warm;

  for (genvar gi = 0; gi < NUM_SW; gi++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_sw_raw (bus.sw_raw[gi]),
      .o_stable (w_stable[gi])
    );
  end

  assign w_next_code = bus.hold ? r_code : w_stable;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_code    <= '0;
      r_valid   <= 1'b0;
      r_changed <= 1'b0;
      r_warm    <= '0;
    end else begin
      r_code    <= w_next_code;
      // Uses the pre-edge valid so the edge that raises valid never pulses
      r_changed <= r_valid && (w_next_code != r_code);
      if (!r_valid) begin
        r_warm <= r_warm + 1'b1;
        if (r_warm == WARM_W'(WARMUP - 1)) begin
          r_valid <= 1'b1;
        end
      end
    end
  end

  assign bus.code         = r_code;
  assign bus.code_valid   = r_valid;
  assign bus.code_changed = r_changed;
endmodule
`default_nettype wire

// File: tb/tb_switch_debounce_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_switch_debounce_encoder : directed checks, SYNC=2, DEBOUNCE=4   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_switch_debounce_encoder;
  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  switch_debounce_encoder_if bus ();

  switch_debounce_encoder #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] c, input logic v, input logic ch);
    chk({tag, ".code"},    32'(bus.code),         32'(c));
    chk({tag, ".valid"},   32'(bus.code_valid),   32'(v));
    chk({tag, ".changed"}, 32'(bus.code_changed), 32'(ch));
  endtask

  initial begin
    rst_n      = 1'b0;
    bus.sw_raw = 3'b111;
    bus.hold   = 1'b0;

    // 1: reset with switches high, then warm-up
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk_all("reset", 3'b000, 1'b0, 1'b0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk_all("warmup", 3'b000, 1'b0, 1'b0);
    end
    step(1);
    chk_all("warm_done", 3'b111, 1'b1, 1'b0);

    // 2: settle to 000, then single rising switch
    bus.sw_raw = 3'b000;
    step(7);
    chk_all("to_zero", 3'b000, 1'b1, 1'b1);
    step(1);
    chk_all("to_zero_end", 3'b000, 1'b1, 1'b0);
    bus.sw_raw = 3'b001;
    step(6);
    chk_all("sw0_e6", 3'b000, 1'b1, 1'b0);
    step(1);
    chk_all("sw0_e7", 3'b001, 1'b1, 1'b1);
    step(1);
    chk_all("sw0_e8", 3'b001, 1'b1, 1'b0);

    // 3: short bounces on sw1 are rejected
    for (int r = 0; r < 5; r++) begin
      bus.sw_raw = 3'b011;
      for (int i = 0; i < 3; i++) begin
        step(1);
        chk("bounce_hi.changed", 32'(bus.code_changed), 32'd0);
      end
      bus.sw_raw = 3'b001;
      for (int i = 0; i < 3; i++) begin
        step(1);
        chk("bounce_lo.changed", 32'(bus.code_changed), 32'd0);
      end
    end
    step(8);
    chk_all("bounce_end", 3'b001, 1'b1, 1'b0);

    // 4: simultaneous and skewed two-channel change
    bus.sw_raw = 3'b000;
    step(8);
    chk_all("back0", 3'b000, 1'b1, 1'b0);
    bus.sw_raw = 3'b101;
    step(6);
    chk_all("simul_e6", 3'b000, 1'b1, 1'b0);
    step(1);
    chk_all("simul_e7", 3'b101, 1'b1, 1'b1);
    step(1);
    chk_all("simul_e8", 3'b101, 1'b1, 1'b0);
    bus.sw_raw = 3'b000;
    step(8);
    chk_all("back0b", 3'b000, 1'b1, 1'b0);
    bus.sw_raw = 3'b001;
    step(2);
    bus.sw_raw = 3'b101;
    step(4);
    chk_all("skew_e6", 3'b000, 1'b1, 1'b0);
    step(1);
    chk_all("skew_e7", 3'b001, 1'b1, 1'b1);
    step(1);
    chk_all("skew_e8", 3'b001, 1'b1, 1'b0);
    step(1);
    chk_all("skew_e9", 3'b101, 1'b1, 1'b1);
    step(1);
    chk_all("skew_e10", 3'b101, 1'b1, 1'b0);

    // 5: hold freezes code; release loads it
    bus.sw_raw = 3'b000;
    step(8);
    chk_all("back0c", 3'b000, 1'b1, 1'b0);
    bus.hold   = 1'b1;
    bus.sw_raw = 3'b100;
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk_all("hold", 3'b000, 1'b1, 1'b0);
    end
    bus.hold = 1'b0;
    step(1);
    chk_all("unhold", 3'b100, 1'b1, 1'b1);
    step(1);
    chk_all("unhold_end", 3'b100, 1'b1, 1'b0);
    bus.hold   = 1'b1;
    bus.sw_raw = 3'b000;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk_all("hold_tog0", 3'b100, 1'b1, 1'b0);
    end
    bus.sw_raw = 3'b100;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk_all("hold_tog1", 3'b100, 1'b1, 1'b0);
    end
    bus.hold = 1'b0;
    step(1);
    chk_all("unhold_same", 3'b100, 1'b1, 1'b0);

    // 6: reset in the middle of a debounce count
    bus.sw_raw = 3'b101;
    step(4);
    chk_all("mid_count", 3'b100, 1'b1, 1'b0);
    rst_n = 1'b0;
    step(1);
    chk_all("mid_reset", 3'b000, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk_all("rewarm", 3'b000, 1'b0, 1'b0);
    end
    step(1);
    chk_all("rewarm_done", 3'b101, 1'b1, 1'b0);
    step(1);
    chk_all("rewarm_after", 3'b101, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
